// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op/state encodings and op decode helpers
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int CNT_W = 5;

  // Ops that occupy the unit for multiple cycles
  function automatic logic is_muldiv(logic [2:0] op);
    return op <= 3'd3;
  endfunction

  function automatic logic is_mult(logic [2:0] op);
    return op[2:1] == 2'b00;
  endfunction

  // Any op that touches HI/LO; the hazard unit stalls D on these while busy|start
  function automatic logic is_mdu_op(logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide result generation for HI/LO
module md_calc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  import mdu_pkg::*;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_sx, b_sx;
  logic [2*WIDTH-1:0]        prod_s, prod_u;
  logic signed [WIDTH-1:0]   q_s, r_s;
  logic [WIDTH-1:0]          q_u, r_u;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign q_s    = $signed(a) / $signed(b);
  assign r_s    = $signed(a) % $signed(b);
  assign q_u    = a / b;
  assign r_u    = a % b;

  // Divide-by-zero and signed overflow are forced so the raw quotient is never used there
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      OP_MULT:  {hi_res, lo_res} = prod_s;
      OP_MULTU: {hi_res, lo_res} = prod_u;
      OP_DIV: begin
        if (b == '0) begin
          lo_res = '1;
          hi_res = a;
        end else if (a == MOST_NEG && b == '1) begin
          lo_res = a;
          hi_res = '0;
        end else begin
          lo_res = q_s;
          hi_res = r_s;
        end
      end
      OP_DIVU: begin
        if (b == '0) begin
          lo_res = '1;
          hi_res = a;
        end else begin
          lo_res = q_u;
          hi_res = r_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pkg::*;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] pend_hi_q, pend_lo_q;
  logic [WIDTH-1:0] pend_hi_d, pend_lo_d;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .a      (a),
    .b      (b),
    .op     (op),
    .hi_res (pend_hi_d),
    .lo_res (pend_lo_d)
  );

  // Result is computed at issue and held; HI/LO only commit on the last RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_muldiv(op)) begin
              pend_hi_q <= pend_hi_d;
              pend_lo_q <= pend_lo_d;
              cnt_q     <= is_mult(op) ? MULT_CNT : DIV_CNT;
              busy_q    <= 1'b1;
              state_q   <= ST_RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 Parameter MULT_CYCLES, default 5, busy cycles for multiply ops (legal range 1..31).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide ops (legal range 1..31).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to issue op from the E stage.
REQ-007 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (no effect).
REQ-008 a  input  WIDTH  rs operand, already forwarded.
REQ-009 b  input  WIDTH  rt operand, already forwarded.
REQ-010 flush  input  1  abort any in-flight op (exception/branch squash).
REQ-011 busy  output  1  high while an op occupies the unit.
REQ-012 hi  output  WIDTH  architectural HI register.
REQ-013 lo  output  WIDTH  architectural LO register.

Function
REQ-014 The unit SHALL implement two states: IDLE and RUN.
REQ-015 In IDLE, start with op 0-3 SHALL latch the computed result into pending registers, load the cycle counter with MULT_CYCLES or DIV_CYCLES, and enter RUN on the next edge.
REQ-016 busy SHALL be driven high for exactly N cycles, starting in the cycle after start, where N is the op's cycle parameter.
REQ-017 On the last RUN cycle (counter = 1) the pending result SHALL be written to HI/LO, and the state SHALL return to IDLE; hi/lo SHALL show the new value in the first cycle busy is low.
REQ-018 MULT/MULTU SHALL produce the full 2*WIDTH product: HI = upper WIDTH bits, LO = lower WIDTH bits; MULT signed, MULTU unsigned.
REQ-019 DIV/DIVU SHALL produce LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; DIV signed, DIVU unsigned.
REQ-020 Divide by zero SHALL yield LO = all ones and HI = a, with no exception raised.
REQ-021 Signed overflow (DIV, a = most-negative, b = -1) SHALL yield LO = a and HI = 0.
REQ-022 MTHI/MTLO with start in IDLE SHALL write a to HI/LO at the next edge, without asserting busy.
REQ-023 Any start while in RUN SHALL be ignored; the pipeline is required to stall on busy or start.
REQ-024 flush SHALL abort RUN at the next edge: state becomes IDLE, busy deasserts, and HI/LO keep their pre-op values.
REQ-025 If flush and start occur in the same cycle in IDLE, flush SHALL win and the op SHALL not be issued.
REQ-026 If flush coincides with the final RUN cycle, the result SHALL be discarded.
REQ-027 Reserved op codes with start SHALL leave state, busy, HI and LO unchanged.

Reset
REQ-028 On reset, at the next clk edge the state SHALL become IDLE, the counter 0, busy 0, and hi, lo and the pending registers 0.
REQ-029 Reset during RUN SHALL abort the op identically, and reset SHALL take priority over flush and start.

Structure
REQ-030 Op encodings and the state encoding SHALL live in the shared package mdu_pkg, together with the MDU op decode used by the hazard logic.
REQ-031 The counter/FSM SHALL be in md_unit; the combinational arithmetic SHALL be one sub-module, md_calc (inputs a, b, op; outputs hi_res, lo_res).
REQ-032 The hazard unit SHALL stall D on (busy | start) when the instruction in D is an MDU or MFHI/MFLO instruction; this is outside md_unit's scope.

Verification
REQ-033 MULT a=0xFFFFFFFE (-2), b=3 -> busy high cycles 1-5; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIVU a=7, b=2 -> busy for 10 cycles; then hi=1, lo=3. DIV a=-7, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-036 MTHI a=0x1234 -> hi=0x1234 next cycle with busy never high; a second start (MTLO) during a MULT's RUN -> ignored, lo=MULT result.
REQ-037 MULT issued, flush in RUN cycle 3 -> busy low next cycle, hi/lo unchanged; reset in RUN cycle 2 -> all outputs 0 next cycle.
REQ-038 Rerun with MULT_CYCLES=1, DIV_CYCLES=31, WIDTH=16 -> busy lengths 1 and 31; MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001.
